// File: rtl/eth_mem_arbiter_if.sv
// Requester-side bus of the packet SRAM arbiter.
// master = requester group, slave = arbiter.
interface eth_mem_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [NUM_PORTS-1:0]                   req_i;
  logic [NUM_PORTS-1:0]                   lock_i;
  logic [NUM_PORTS-1:0]                   we_i;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]   addr_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i;
  logic [NUM_PORTS-1:0]                   gnt_o;
  logic [NUM_PORTS-1:0]                   rvalid_o;
  logic [DATA_WIDTH-1:0]                  rdata_o;

  modport master (
    output req_i, lock_i, we_i,
    output addr_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, lock_i, we_i,
    input  addr_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/eth_mem_arbiter.sv
// Round-robin arbiter with bounded burst lock
// in front of a 1-cycle-latency packet SRAM.
module eth_mem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LOCK   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  eth_mem_arbiter_if.slave        bus,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = $clog2(MAX_LOCK + 1);

  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic                 lock_vld_q, lock_vld_d;
  logic [CW-1:0]        lock_cnt_q, lock_cnt_d;
  logic [CW-1:0]        cnt_nxt;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0] gnt;
  logic [PW-1:0]        gnt_idx;
  logic                 gnt_vld;
  logic                 lock_act;
  logic [PW1-1:0]       cand;

  assign lock_act = lock_vld_q && bus.req_i[owner_q];

  // Pick the winner: locked owner, else first requester from rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (lock_act) begin
      gnt_vld = 1'b1;
      gnt_idx = owner_q;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        cand = {1'b0, rr_ptr_q} + PW1'(i);
        if (cand >= PW1'(NUM_PORTS)) begin
          cand = cand - PW1'(NUM_PORTS);
        end
        if (!gnt_vld && bus.req_i[cand[PW-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand[PW-1:0];
        end
      end
    end
  end

  // One-hot grant vector.
  always_comb begin
    gnt = '0;
    if (gnt_vld) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = mem_rdata_i;

  // SRAM mux; idle cycles drive the whole bus to zero.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (gnt_vld) begin
      mem_req_o   = 1'b1;
      mem_we_o    = bus.we_i[gnt_idx];
      mem_addr_o  = bus.addr_i[gnt_idx];
      mem_be_o    = bus.be_i[gnt_idx];
      mem_wdata_o = bus.wdata_i[gnt_idx];
    end
  end

  // Next priority, lock window and read-return routing.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_vld_d = 1'b0;
    lock_cnt_d = '0;
    rvalid_d   = '0;
    if (lock_vld_q && (owner_q == gnt_idx)) begin
      cnt_nxt = lock_cnt_q + 1'b1;
    end else begin
      cnt_nxt = CW'(1);
    end
    if (gnt_vld) begin
      if (gnt_idx == PW'(NUM_PORTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = gnt_idx + 1'b1;
      end
      if (bus.lock_i[gnt_idx] &&
          (cnt_nxt < CW'(MAX_LOCK))) begin
        lock_vld_d = 1'b1;
        owner_d    = gnt_idx;
        lock_cnt_d = cnt_nxt;
      end
      if (!bus.we_i[gnt_idx]) begin
        rvalid_d[gnt_idx] = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_vld_q <= 1'b0;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_vld_q <= lock_vld_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_eth_mem_arbiter.sv
// Bench for eth_mem_arbiter: directed scenarios
// plus random traffic against a reference model.
module tb_eth_mem_arbiter;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;
  localparam int ML = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  eth_mem_arbiter_if #(
    .NUM_PORTS (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) bus ();

  eth_mem_arbiter #(
    .NUM_PORTS (N),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .MAX_LOCK  (ML)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_be_o   (mem_be),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM behaviour: 16 words, 1-cycle read latency.
  logic [DW-1:0] sram    [16];
  logic [DW-1:0] ref_mem [16];

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++) begin
          if (mem_be[b]) begin
            sram[mem_addr[6:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
          end
        end
      end else begin
        mem_rdata <= sram[mem_addr[6:3]];
      end
    end
  end

  function automatic logic [63:0] word(int i);
    return {16'hC0DE, 16'(i), 16'h5EED, 16'(i * 7)};
  endfunction

  // Reference model state.
  int            m_ptr;
  int            m_owner;
  int            m_cnt;
  int            m_rv;
  logic [DW-1:0] m_rdata;
  bit            chk_en;
  logic [N-1:0]  obs_gnt;
  logic [AW-1:0] obs_addr;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(int p, bit r, bit l, bit w,
                       logic [AW-1:0] a,
                       logic [DW-1:0] d,
                       logic [BW-1:0] be);
    bus.req_i[p]   = r;
    bus.lock_i[p]  = l;
    bus.we_i[p]    = w;
    bus.addr_i[p]  = a;
    bus.wdata_i[p] = d;
    bus.be_i[p]    = be;
  endtask

  task automatic idle_all();
    for (int p = 0; p < N; p++) begin
      drive(p, 0, 0, 0, '0, '0, '0);
    end
  endtask

  // One clock: check at negedge, advance model, step past posedge.
  task automatic tick();
    int g;
    int n;
    int idx;
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    @(negedge clk);
    g = -1;
    if (m_owner >= 0 && bus.req_i[m_owner]) begin
      g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        automatic int p = (m_ptr + k) % N;
        if (g < 0 && bus.req_i[p]) g = p;
      end
    end
    eg  = (g < 0) ? '0 : N'(1) << g;
    erv = (m_rv < 0) ? '0 : N'(1) << m_rv;
    obs_gnt  = bus.gnt_o;
    obs_addr = mem_addr;
    if (chk_en) begin
      chk("gnt", bus.gnt_o, eg);
      chk("mem_req", mem_req, (g >= 0));
      chk("mem_we", mem_we, (g >= 0) ? bus.we_i[g] : 1'b0);
      chk("mem_addr", mem_addr, (g >= 0) ? bus.addr_i[g] : '0);
      chk("mem_be", mem_be, (g >= 0) ? bus.be_i[g] : '0);
      chk("mem_wdata", mem_wdata,
          (g >= 0) ? bus.wdata_i[g] : '0);
      chk("rvalid", bus.rvalid_o, erv);
      if (m_rv >= 0) chk("rdata", bus.rdata_o, m_rdata);
    end
    m_rv = -1;
    if (g >= 0) begin
      idx = int'(bus.addr_i[g][6:3]);
      if (bus.we_i[g]) begin
        for (int b = 0; b < BW; b++) begin
          if (bus.be_i[g][b]) begin
            ref_mem[idx][b*8 +: 8] = bus.wdata_i[g][b*8 +: 8];
          end
        end
      end else begin
        m_rv    = g;
        m_rdata = ref_mem[idx];
      end
      n = (m_owner == g) ? m_cnt + 1 : 1;
      if (bus.lock_i[g] && n < ML) begin
        m_owner = g;
        m_cnt   = n;
      end else begin
        m_owner = -1;
        m_cnt   = 0;
      end
      m_ptr = (g + 1) % N;
    end else begin
      m_owner = -1;
      m_cnt   = 0;
    end
    if (rst) begin
      m_ptr   = 0;
      m_owner = -1;
      m_cnt   = 0;
      m_rv    = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int c1;
    logic [N-1:0] eg;
    for (int i = 0; i < 16; i++) begin
      sram[i]    = word(i);
      ref_mem[i] = word(i);
    end
    m_ptr   = 0;
    m_owner = -1;
    m_cnt   = 0;
    m_rv    = -1;
    chk_en  = 0;
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1;

    // Reset state.
    chk("rst_rvalid", bus.rvalid_o, '0);
    chk("rst_memreq", mem_req, 1'b0);
    tick();

    // Single read from port 1.
    drive(1, 1, 0, 0, 64'h40, '0, '1);
    tick();
    chk("tp1_gnt", obs_gnt, 2'b10);
    chk("tp1_addr", obs_addr, 64'h40);
    idle_all();
    chk("tp1_rvalid", bus.rvalid_o, 2'b10);
    chk("tp1_rdata", bus.rdata_o, word(8));
    tick();

    // Contention: alternate 0,1,0,1 from reset.
    do_reset();
    drive(0, 1, 0, 0, 64'h00, '0, '1);
    drive(1, 1, 0, 0, 64'h18, '0, '1);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_alt", obs_gnt, eg);
      c0 += int'(obs_gnt[0]);
      c1 += int'(obs_gnt[1]);
    end
    chk("rr_cnt0", 64'(c0), 64'd10);
    chk("rr_cnt1", 64'(c1), 64'd10);

    // Locked 4-beat write burst from port 1.
    do_reset();
    drive(0, 1, 0, 0, 64'h00, '0, '1);
    tick();
    chk("lb_pre", obs_gnt, 2'b01);
    for (int b = 0; b < 4; b++) begin
      drive(1, 1, (b < 3), 1, 64'h78,
            64'hABCD_0000_0000_0000 + 64'(b), 8'h0F);
      tick();
      chk("lb_beat", obs_gnt, 2'b10);
    end
    drive(1, 0, 0, 0, '0, '0, '0);
    tick();
    chk("lb_after", obs_gnt, 2'b01);

    // Starvation bound: 16 locked grants, then port 1.
    do_reset();
    drive(0, 1, 1, 0, 64'h20, '0, '1);
    drive(1, 1, 0, 0, 64'h28, '0, '1);
    for (int i = 0; i < 18; i++) begin
      tick();
      eg = (i == 16) ? 2'b10 : 2'b01;
      chk("starve", obs_gnt, eg);
    end

    // Interleaved reads.
    do_reset();
    drive(0, 1, 0, 0, 64'h08, '0, '1);
    tick();
    idle_all();
    drive(1, 1, 0, 0, 64'h10, '0, '1);
    chk("il_rv0", bus.rvalid_o, 2'b01);
    chk("il_rd0", bus.rdata_o, word(1));
    tick();
    idle_all();
    chk("il_rv1", bus.rvalid_o, 2'b10);
    chk("il_rd1", bus.rdata_o, word(2));
    tick();

    // Reset during the third beat of a locked read burst.
    do_reset();
    drive(0, 1, 0, 0, 64'h00, '0, '1);
    tick();
    drive(1, 1, 1, 0, 64'h30, '0, '1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rml_beat3", obs_gnt, 2'b10);
    rst = 1'b0;
    chk("rml_rvalid", bus.rvalid_o, '0);
    drive(1, 1, 0, 0, 64'h30, '0, '1);
    tick();
    chk("rml_restart", obs_gnt, 2'b01);

    // Random traffic; requests hold until granted.
    idle_all();
    for (int i = 0; i < 800; i++) begin
      for (int p = 0; p < N; p++) begin
        if (!(bus.req_i[p] && !obs_gnt[p])) begin
          drive(p, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 3) != 0),
                $urandom_range(0, 1) == 1,
                {$urandom, $urandom},
                {$urandom, $urandom},
                BW'($urandom));
        end
      end
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
